fetch_unit: RTL and testbench

- Instruction-fetch stage of the RISC-V core.
- Owns the PC and issues one word request at a time to instruction memory over a req/gnt/rvalid protocol.
- Holds the returned instruction in a one-entry output register with a valid/ready handshake.
- Breaks the instruction out into op/funct3/funct7 for the main and ALU decoders directly downstream; accepts branch/jump redirects from execute.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: datapath width, NOP encoding, instruction field
// positions and the fetch FSM state type.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int OP_LSB = 0;
  localparam int OP_MSB = 6;
  localparam int F3_LSB = 12;
  localparam int F3_MSB = 14;
  localparam int F7_LSB = 25;
  localparam int F7_MSB = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one imem request at a time and holds
// the returned word in a one-entry valid/ready output register.
module fetch_unit #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            instr_ready,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7
);
  import riscv_pkg::*;

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] inflight_pc_q;
  logic [XLEN-1:0] instr_pc_q;
  logic [31:0]     instr_q;
  logic            instr_valid_q;
  logic            kill_q;
  logic            consume;
  logic            granted;

  // Requests only go out when the output register will be free by the time
  // the response lands, so an rvalid never needs to be back-pressured.
  assign imem_req  = (state_q == REQ) && (!instr_valid_q || instr_ready);
  assign imem_addr = pc_q;
  assign granted   = imem_req && imem_gnt;
  assign consume   = instr_valid_q && instr_ready;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~XLEN'(3);
    end else if (granted) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP;
      instr_pc_q    <= '0;
    end else begin
      pc_q <= pc_d;
      if (consume) begin
        instr_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (granted) begin
            inflight_pc_q <= pc_q;
            state_q       <= WAIT;
            // A redirect on the grant cycle orphans the request just issued.
            if (redirect_valid) begin
              kill_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_q <= REQ;
            kill_q  <= 1'b0;
            if (!kill_q && !redirect_valid) begin
              instr_q       <= imem_rdata;
              instr_pc_q    <= inflight_pc_q;
              instr_valid_q <= 1'b1;
            end
          end else if (redirect_valid) begin
            kill_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (redirect_valid) begin
        instr_valid_q <= 1'b0;
      end
    end
  end

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign op          = instr_q[OP_MSB:OP_LSB];
  assign funct3      = instr_q[F3_MSB:F3_LSB];
  assign funct7      = instr_q[F7_MSB:F7_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected grants and instructions are queued
// by the stimulus and checked against what the DUT presents.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  int total = 0;
  int bad   = 0;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];

  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          rdelay;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_ready(instr_ready), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .op(op), .funct3(funct3), .funct7(funct7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h00A0_0093;
      32'hFFFF_FFFC: return 32'h40B5_0533;
      default:       return {a[23:0], 8'h13};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every accepted instruction must match the head of the scoreboard.
  always @(negedge clk) begin
    if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL instr_unexpected actual=%h@%h required=none", instr, instr_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("instr", instr, e.ins);
        chk("instr_pc", instr_pc, e.pc);
        chk("op", {25'd0, op}, {25'd0, e.ins[6:0]});
        chk("funct3", {29'd0, funct3}, {29'd0, e.ins[14:12]});
        chk("funct7", {25'd0, funct7}, {25'd0, e.ins[31:25]});
      end
    end
  end

  // One clock: check/record any grant before the edge, then drive the memory
  // response for the following cycle.
  task automatic step();
    @(negedge clk);
    if (imem_req === 1'b1 && imem_gnt === 1'b1) begin
      if (addr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL grant_unexpected actual=%h required=none", imem_addr);
      end else begin
        chk("grant_addr", imem_addr, addr_q.pop_front());
      end
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = rdelay;
    end
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memf(pend_addr);
        pend        = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (instr_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (instr_valid !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=%b required=1", name, instr_valid);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    e.pc  = pc;
    e.ins = ins;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    imem_gnt = 1'b0;
    step();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("addr_q_drained", addr_q.size(), 0);
    rst            = 1'b1;
    pend           = 1'b0;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    pend = 1'b0;
    pend_addr = '0;
    pend_cnt = 0;
    rdelay = 0;
    step();
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_op", {25'd0, op}, 32'h13);
    chk("rst_funct7", {25'd0, funct7}, 32'h0);

    // Boot with free-flowing decode
    addr_q.push_back(32'h100); addr_q.push_back(32'h104); addr_q.push_back(32'h108);
    push(32'h100, 32'h00A0_0093);
    push(32'h104, 32'h0001_0413);
    push(32'h108, 32'h0001_0813);
    instr_ready = 1'b1;
    imem_gnt = 1'b1;
    rst = 1'b0;
    wait_valid("boot");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("boot_valid_pulse", {31'd0, instr_valid}, (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    do_reset();

    // Back-pressure, then redirects
    instr_ready = 1'b0;
    imem_gnt = 1'b1;
    addr_q.push_back(32'h100); addr_q.push_back(32'h104); addr_q.push_back(32'h200);
    push(32'h100, 32'h00A0_0093);
    push(32'h200, 32'h0002_0013);
    rst = 1'b0;
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_req", {31'd0, imem_req}, 32'd0);
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_instr", instr, 32'h00A0_0093);
      chk("bp_instr_pc", instr_pc, 32'h100);
    end
    instr_ready = 1'b1;
    rdelay = 1;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    step();
    redirect_valid = 1'b0;
    step();
    rdelay = 0;
    chk("rdw_valid", {31'd0, instr_valid}, 32'd0);
    chk("rdw_addr", imem_addr, 32'h200);
    wait_valid("rdw");

    addr_q.push_back(32'h204); addr_q.push_back(32'h400);
    push(32'h400, 32'h0004_0013);
    chk("rdg_addr", imem_addr, 32'h204);
    redirect_valid = 1'b1;
    redirect_pc = 32'h400;
    step();
    redirect_valid = 1'b0;
    chk("rdg_valid", {31'd0, instr_valid}, 32'd0);
    step();
    wait_valid("rdg");

    addr_q.push_back(32'hFFFF_FFFC);
    push(32'hFFFF_FFFC, 32'h40B5_0533);
    imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    imem_gnt = 1'b1;
    chk("wrap_req", {31'd0, imem_req}, 32'd1);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    wait_valid("wrap");
    chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_op", {25'd0, op}, 32'h33);
    chk("wrap_funct3", {29'd0, funct3}, 32'h0);
    chk("wrap_funct7", {25'd0, funct7}, 32'h20);
    chk("wrap_next_addr", imem_addr, 32'h0);
    do_reset();

    // Async reset while a request is in flight
    instr_ready = 1'b1;
    imem_gnt = 1'b1;
    rdelay = 0;
    addr_q.push_back(32'h100); addr_q.push_back(32'h104); addr_q.push_back(32'h100);
    push(32'h100, 32'h00A0_0093);
    push(32'h100, 32'h00A0_0093);
    rst = 1'b0;
    wait_valid("ar_first");
    rdelay = 1;
    step();
    #1;
    rst = 1'b1;
    #1;
    chk("ar_req", {31'd0, imem_req}, 32'd0);
    chk("ar_valid", {31'd0, instr_valid}, 32'd0);
    chk("ar_instr", instr, 32'h0000_0013);
    chk("ar_instr_pc", instr_pc, 32'h0);
    chk("ar_op", {25'd0, op}, 32'h13);
    chk("ar_addr", imem_addr, 32'h100);
    rdelay = 0;
    rst = 1'b0;
    step();
    chk("ar_idle_valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("ar_late_rvalid", {31'd0, instr_valid}, 32'd0);
    wait_valid("ar_restart");
    imem_gnt = 1'b0;
    step();
    chk("end_exp_q", exp_q.size(), 0);
    chk("end_addr_q", addr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
